// File: rtl/aes_pkg.sv
// Shared AES definitions: key-length encodings, round counts and the key controller FSM states.
package aes_pkg;

    localparam logic [1:0] AES_128_BIT_KEY = 2'b00;
    localparam logic [1:0] AES_256_BIT_KEY = 2'b01;
    localparam logic [1:0] AES_192_BIT_KEY = 2'b10;
    localparam logic [1:0] AES_ILLEGAL_KEY = 2'b11;

    localparam logic [3:0] AES_128_ROUNDS = 4'd10;
    localparam logic [3:0] AES_192_ROUNDS = 4'd12;
    localparam logic [3:0] AES_256_ROUNDS = 4'd14;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_INIT  = 3'd1;
    localparam logic [2:0] ST_ARM   = 3'd2;
    localparam logic [2:0] ST_WAIT  = 3'd3;
    localparam logic [2:0] ST_READY = 3'd4;
    localparam logic [2:0] ST_FAULT = 3'd5;

    function automatic logic [3:0] keylen_to_rounds(input logic [1:0] keylen);
        case (keylen)
            AES_128_BIT_KEY: keylen_to_rounds = AES_128_ROUNDS;
            AES_192_BIT_KEY: keylen_to_rounds = AES_192_ROUNDS;
            AES_256_BIT_KEY: keylen_to_rounds = AES_256_ROUNDS;
            default:         keylen_to_rounds = 4'd0;
        endcase
    endfunction

endpackage

// File: rtl/aes_key_ctrl.sv
// Key-load sequencer in front of the AES key-expansion memory, with expansion watchdog and start gating.
// Optional feature: define AES_KEY_CTRL_ZEROIZE_EN to add the zeroize input.
module aes_key_ctrl
    import aes_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 64
) (
    input  logic         clk,
    input  logic         reset_n,
`ifdef AES_KEY_CTRL_ZEROIZE_EN
    input  logic         zeroize,
`endif
    input  logic         cmd_valid,
    output logic         cmd_ready,
    input  logic [255:0] cmd_key,
    input  logic [1:0]   cmd_keylen,
    output logic         cmd_err,
    output logic         km_init,
    output logic [255:0] km_key,
    output logic [1:0]   km_keylen,
    input  logic         km_ready,
    input  logic         cipher_busy,
    input  logic         cipher_start_req,
    output logic         cipher_start_gnt,
    output logic         key_valid,
    output logic [3:0]   num_rounds,
    output logic         timeout_err
);

    localparam logic [7:0] TIMER_LAST = 8'(TIMEOUT_CYCLES - 1);

    logic         zeroize_w;
`ifdef AES_KEY_CTRL_ZEROIZE_EN
    assign zeroize_w = zeroize;
`else
    assign zeroize_w = 1'b0;
`endif

    logic [2:0]   state_q, state_d;
    logic [7:0]   timer_q, timer_d;
    logic [255:0] km_key_q, km_key_d;
    logic [1:0]   km_keylen_q, km_keylen_d;
    logic         key_valid_q, key_valid_d;
    logic         timeout_err_q, timeout_err_d;
    logic         cmd_err_q, cmd_err_d;
    logic         km_init_q, km_init_d;
    logic         zero_pend_q, zero_pend_d;

    logic         accept_state;
    logic         cmd_fire;
    logic         cmd_legal;

    assign accept_state = (state_q == ST_IDLE) || (state_q == ST_READY) || (state_q == ST_FAULT);
    // A pending start request in READY takes priority so the key cannot change under a new block.
    assign cmd_ready    = accept_state && !cipher_busy && !zeroize_w
                          && !((state_q == ST_READY) && cipher_start_req);
    assign cmd_fire     = cmd_valid && cmd_ready;
    assign cmd_legal    = (cmd_keylen != AES_ILLEGAL_KEY);

    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
        state_d       = state_q;
        timer_d       = timer_q;
        km_key_d      = km_key_q;
        km_keylen_d   = km_keylen_q;
        key_valid_d   = key_valid_q;
        timeout_err_d = timeout_err_q;
        zero_pend_d   = zero_pend_q;
        cmd_err_d     = 1'b0;

        if (zeroize_w) begin
            km_key_d      = '0;
            km_keylen_d   = AES_128_BIT_KEY;
            key_valid_d   = 1'b0;
            timeout_err_d = 1'b0;
            zero_pend_d   = 1'b1;
            state_d       = ST_INIT;
        end else if (cmd_fire && !cmd_legal) begin
            cmd_err_d = 1'b1;
        end else if (cmd_fire) begin
            km_key_d      = cmd_key;
            km_keylen_d   = cmd_keylen;
            key_valid_d   = 1'b0;
            timeout_err_d = 1'b0;
            zero_pend_d   = 1'b0;
            state_d       = ST_INIT;
        end else begin
            case (state_q)
                ST_INIT: state_d = ST_ARM;
                // km_ready is still stale here: the key memory drops it one cycle after init.
                ST_ARM: begin
                    timer_d = '0;
                    state_d = ST_WAIT;
                end
                ST_WAIT: begin
                    timer_d = timer_q + 8'd1;
                    if (km_ready) begin
                        zero_pend_d = 1'b0;
                        state_d     = zero_pend_q ? ST_IDLE : ST_READY;
                        key_valid_d = !zero_pend_q;
                    end else if (timer_q == TIMER_LAST) begin
                        timeout_err_d = 1'b1;
                        state_d       = ST_FAULT;
                    end
                end
                ST_IDLE, ST_READY, ST_FAULT: ;
                default: state_d = ST_IDLE;
            endcase
        end

        km_init_d = (state_d == ST_INIT);
    end

    // NOTE: state flops use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= ST_IDLE;
            timer_q       <= '0;
            km_key_q      <= '0;
            km_keylen_q   <= AES_128_BIT_KEY;
            key_valid_q   <= 1'b0;
            timeout_err_q <= 1'b0;
            cmd_err_q     <= 1'b0;
            km_init_q     <= 1'b0;
            zero_pend_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            timer_q       <= timer_d;
            km_key_q      <= km_key_d;
            km_keylen_q   <= km_keylen_d;
            key_valid_q   <= key_valid_d;
            timeout_err_q <= timeout_err_d;
            cmd_err_q     <= cmd_err_d;
            km_init_q     <= km_init_d;
            zero_pend_q   <= zero_pend_d;
        end
    end

    assign km_init          = km_init_q;
    assign km_key           = km_key_q;
    assign km_keylen        = km_keylen_q;
    assign key_valid        = key_valid_q;
    assign timeout_err      = timeout_err_q;
    assign cmd_err          = cmd_err_q;
    assign num_rounds       = key_valid_q ? keylen_to_rounds(km_keylen_q) : 4'd0;
    assign cipher_start_gnt = (state_q == ST_READY) && cipher_start_req && !cipher_busy && !zeroize_w;

endmodule

// File: tb/tb_aes_key_ctrl.sv
// Directed bench for aes_key_ctrl; define AES_KEY_CTRL_ZEROIZE_EN to also exercise zeroize.
module tb_aes_key_ctrl;

    logic         clk = 1'b0;
    logic         reset_n;
    logic         cmd_valid;
    logic         cmd_ready;
    logic [255:0] cmd_key;
    logic [1:0]   cmd_keylen;
    logic         cmd_err;
    logic         km_init;
    logic [255:0] km_key;
    logic [1:0]   km_keylen;
    logic         km_ready;
    logic         cipher_busy;
    logic         cipher_start_req;
    logic         cipher_start_gnt;
    logic         key_valid;
    logic [3:0]   num_rounds;
    logic         timeout_err;
`ifdef AES_KEY_CTRL_ZEROIZE_EN
    logic         zeroize;
`endif

    int checks = 0;
    int errors = 0;

    localparam logic [255:0] K128 = {128'h000102030405060708090a0b0c0d0e0f, 128'h0};
    localparam logic [255:0] K192 = {192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b, 64'h0};
    localparam logic [255:0] K256 = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;

    aes_key_ctrl #(.TIMEOUT_CYCLES(64)) dut (
        .clk              (clk),
        .reset_n          (reset_n),
`ifdef AES_KEY_CTRL_ZEROIZE_EN
        .zeroize          (zeroize),
`endif
        .cmd_valid        (cmd_valid),
        .cmd_ready        (cmd_ready),
        .cmd_key          (cmd_key),
        .cmd_keylen       (cmd_keylen),
        .cmd_err          (cmd_err),
        .km_init          (km_init),
        .km_key           (km_key),
        .km_keylen        (km_keylen),
        .km_ready         (km_ready),
        .cipher_busy      (cipher_busy),
        .cipher_start_req (cipher_start_req),
        .cipher_start_gnt (cipher_start_gnt),
        .key_valid        (key_valid),
        .num_rounds       (num_rounds),
        .timeout_err      (timeout_err)
    );

    always #5 clk = ~clk;

    // Advance one clock; inputs are then driven and outputs sampled 1 ns after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0; cmd_valid = 1'b0; cmd_key = '0; cmd_keylen = 2'b00;
        km_ready = 1'b0; cipher_busy = 1'b0; cipher_start_req = 1'b0;
`ifdef AES_KEY_CTRL_ZEROIZE_EN
        zeroize = 1'b0;
`endif
        #12;
        checks++; if (km_init !== 1'b0) begin errors++; $display("FAIL reset_km_init: got %b expected 0", km_init); end
        checks++; if (km_key !== 256'h0) begin errors++; $display("FAIL reset_km_key: got %h expected 0", km_key); end
        checks++; if (key_valid !== 1'b0 || timeout_err !== 1'b0 || cmd_err !== 1'b0)
            begin errors++; $display("FAIL reset_flags: got kv=%b to=%b err=%b expected 0/0/0", key_valid, timeout_err, cmd_err); end
        checks++; if (num_rounds !== 4'd0) begin errors++; $display("FAIL reset_num_rounds: got %0d expected 0", num_rounds); end
        step();
        reset_n = 1'b1;
        step();
        checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL idle_cmd_ready: got %b expected 1", cmd_ready); end
    endtask

    task automatic test_legal_128();
        int pulses;
        int early;
        cmd_valid = 1'b1; cmd_keylen = 2'b00; cmd_key = K128;
        step();                               // cycle 1: INIT
        cmd_valid = 1'b0; cmd_key = '0;
        pulses = km_init ? 1 : 0;
        early  = 0;
        checks++; if (km_init !== 1'b1) begin errors++; $display("FAIL l128_init_pulse: got %b expected 1", km_init); end
        checks++; if (km_key !== K128 || km_keylen !== 2'b00)
            begin errors++; $display("FAIL l128_latch: got %h/%b expected %h/00", km_key, km_keylen, K128); end
        for (int c = 2; c <= 14; c++) begin
            step();
            if (km_init) pulses++;
            if (key_valid) early++;
            if (c == 14) km_ready = 1'b1;
        end
        checks++; if (pulses !== 1) begin errors++; $display("FAIL l128_init_count: got %0d expected 1", pulses); end
        checks++; if (early !== 0) begin errors++; $display("FAIL l128_early_valid: got %0d expected 0", early); end
        step();                               // cycle 15: READY
        checks++; if (key_valid !== 1'b1 || num_rounds !== 4'd10)
            begin errors++; $display("FAIL l128_ready: got kv=%b nr=%0d expected 1/10", key_valid, num_rounds); end
    endtask

    task automatic test_illegal_keylen();
        cmd_valid = 1'b1; cmd_keylen = 2'b11; cmd_key = K256;
        #1;
        checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL ill_cmd_ready: got %b expected 1", cmd_ready); end
        step();
        cmd_valid = 1'b0;
        checks++; if (cmd_err !== 1'b1) begin errors++; $display("FAIL ill_cmd_err: got %b expected 1", cmd_err); end
        checks++; if (km_init !== 1'b0) begin errors++; $display("FAIL ill_no_init: got %b expected 0", km_init); end
        checks++; if (key_valid !== 1'b1 || num_rounds !== 4'd10)
            begin errors++; $display("FAIL ill_key_valid: got kv=%b nr=%0d expected 1/10", key_valid, num_rounds); end
        checks++; if (km_key !== K128 || km_keylen !== 2'b00)
            begin errors++; $display("FAIL ill_key_kept: got %h/%b expected %h/00", km_key, km_keylen, K128); end
        step();
        checks++; if (cmd_err !== 1'b0) begin errors++; $display("FAIL ill_err_pulse: got %b expected 0", cmd_err); end
    endtask

    task automatic test_grant_contention();
        cipher_start_req = 1'b1; cipher_busy = 1'b1;
        #1;
        checks++; if (cipher_start_gnt !== 1'b0) begin errors++; $display("FAIL gnt_busy: got %b expected 0", cipher_start_gnt); end
        cipher_busy = 1'b0; cmd_valid = 1'b1; cmd_keylen = 2'b10; cmd_key = K192;
        #1;
        checks++; if (cipher_start_gnt !== 1'b1) begin errors++; $display("FAIL gnt_contend: got %b expected 1", cipher_start_gnt); end
        checks++; if (cmd_ready !== 1'b0) begin errors++; $display("FAIL ready_contend: got %b expected 0", cmd_ready); end
        step();
        cipher_start_req = 1'b0; cipher_busy = 1'b1;
        #1;
        checks++; if (km_init !== 1'b0 || key_valid !== 1'b1 || cmd_ready !== 1'b0)
            begin errors++; $display("FAIL cmd_held_busy: got init=%b kv=%b rdy=%b expected 0/1/0", km_init, key_valid, cmd_ready); end
        step();
        cipher_busy = 1'b0;
        #1;
        checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL ready_after_busy: got %b expected 1", cmd_ready); end
        step();                               // cycle 1: INIT, km_ready still stale-high
        cmd_valid = 1'b0;
        checks++; if (km_init !== 1'b1 || km_keylen !== 2'b10 || km_key !== K192 || key_valid !== 1'b0)
            begin errors++; $display("FAIL c192_accept: got init=%b kl=%b kv=%b expected 1/10/0", km_init, km_keylen, key_valid); end
        step();                               // cycle 2: ARM, stale km_ready ignored
        step();                               // cycle 3: WAIT
        checks++; if (key_valid !== 1'b0) begin errors++; $display("FAIL arm_ignores_ready: got %b expected 0", key_valid); end
        km_ready = 1'b0;
        repeat (4) step();
        km_ready = 1'b1;
        step();
        checks++; if (key_valid !== 1'b1 || num_rounds !== 4'd12)
            begin errors++; $display("FAIL c192_ready: got kv=%b nr=%0d expected 1/12", key_valid, num_rounds); end
    endtask

    task automatic test_timeout();
        int bad;
        bad = 0;
        cmd_valid = 1'b1; cmd_keylen = 2'b01; cmd_key = K256;
        step();                               // cycle 1: INIT
        cmd_valid = 1'b0;
        step();                               // cycle 2: ARM
        km_ready = 1'b0; cipher_start_req = 1'b1;
        step();                               // cycle 3: WAIT, timer 0
        for (int c = 3; c < 66; c++) begin
            if (cipher_start_gnt || timeout_err || key_valid) bad++;
            step();
        end
        checks++; if (bad !== 0 || timeout_err !== 1'b0)
            begin errors++; $display("FAIL to_wait_phase: got bad=%0d to=%b expected 0/0", bad, timeout_err); end
        step();                               // cycle 67: FAULT
        checks++; if (timeout_err !== 1'b1 || key_valid !== 1'b0 || num_rounds !== 4'd0)
            begin errors++; $display("FAIL to_fault: got to=%b kv=%b nr=%0d expected 1/0/0", timeout_err, key_valid, num_rounds); end
        checks++; if (cipher_start_gnt !== 1'b0 || cmd_ready !== 1'b1)
            begin errors++; $display("FAIL to_fault_hs: got gnt=%b rdy=%b expected 0/1", cipher_start_gnt, cmd_ready); end
        cmd_valid = 1'b1; cmd_keylen = 2'b11;
        step();
        cmd_valid = 1'b0;
        checks++; if (cmd_err !== 1'b1 || timeout_err !== 1'b1 || km_init !== 1'b0 || km_keylen !== 2'b01)
            begin errors++; $display("FAIL to_illegal: got err=%b to=%b init=%b kl=%b expected 1/1/0/01", cmd_err, timeout_err, km_init, km_keylen); end
        cipher_start_req = 1'b0; cmd_valid = 1'b1; cmd_keylen = 2'b10; cmd_key = K192;
        step();
        cmd_valid = 1'b0;
        checks++; if (timeout_err !== 1'b0 || km_init !== 1'b1)
            begin errors++; $display("FAIL to_clear: got to=%b init=%b expected 0/1", timeout_err, km_init); end
    endtask

    task automatic test_async_reset();
        step();                               // ARM
        step();                               // WAIT
        #2;
        reset_n = 1'b0;
        #1;
        checks++; if (km_key !== 256'h0 || km_keylen !== 2'b00)
            begin errors++; $display("FAIL ar_key: got %h/%b expected 0/00", km_key, km_keylen); end
        checks++; if (km_init !== 1'b0 || key_valid !== 1'b0 || num_rounds !== 4'd0 || timeout_err !== 1'b0 || cmd_err !== 1'b0 || cipher_start_gnt !== 1'b0)
            begin errors++; $display("FAIL ar_outputs: got init=%b kv=%b nr=%0d to=%b err=%b gnt=%b expected all 0",
                                     km_init, key_valid, num_rounds, timeout_err, cmd_err, cipher_start_gnt); end
        step();
        reset_n = 1'b1;
        step();
        cmd_valid = 1'b1; cmd_keylen = 2'b10; cmd_key = K192;
        step();
        cmd_valid = 1'b0;
        checks++; if (km_init !== 1'b1) begin errors++; $display("FAIL ar_reload_init: got %b expected 1", km_init); end
        step();
        step();
        km_ready = 1'b1;
        step();
        checks++; if (key_valid !== 1'b1 || num_rounds !== 4'd12)
            begin errors++; $display("FAIL ar_reload_ready: got kv=%b nr=%0d expected 1/12", key_valid, num_rounds); end
    endtask

`ifdef AES_KEY_CTRL_ZEROIZE_EN
    task automatic test_zeroize();
        zeroize = 1'b1; cmd_valid = 1'b1; cmd_keylen = 2'b00; cmd_key = K128; cipher_start_req = 1'b1;
        #1;
        checks++; if (cmd_ready !== 1'b0 || cipher_start_gnt !== 1'b0)
            begin errors++; $display("FAIL zz_priority: got rdy=%b gnt=%b expected 0/0", cmd_ready, cipher_start_gnt); end
        step();
        zeroize = 1'b0; cmd_valid = 1'b0; cipher_start_req = 1'b0;
        checks++; if (km_init !== 1'b1 || km_key !== 256'h0 || km_keylen !== 2'b00 || key_valid !== 1'b0)
            begin errors++; $display("FAIL zz_clear: got init=%b key=%h kl=%b kv=%b expected 1/0/00/0", km_init, km_key, km_keylen, key_valid); end
        step();
        step();
        step();
        cipher_start_req = 1'b1;
        #1;
        checks++; if (key_valid !== 1'b0 || cmd_ready !== 1'b1 || cipher_start_gnt !== 1'b0)
            begin errors++; $display("FAIL zz_idle: got kv=%b rdy=%b gnt=%b expected 0/1/0", key_valid, cmd_ready, cipher_start_gnt); end
        cipher_start_req = 1'b0;
    endtask
`endif

    initial begin
        test_reset();
        test_legal_128();
        test_illegal_keylen();
        test_grant_contention();
`ifdef AES_KEY_CTRL_ZEROIZE_EN
        test_zeroize();
        km_ready = 1'b1;
        cmd_valid = 1'b1; cmd_keylen = 2'b00; cmd_key = K128;
        step();
        cmd_valid = 1'b0;
        repeat (4) step();
`endif
        test_timeout();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
